// File: rtl/sdf_stage_4.sv
// Radix-2 DIF single-path delay-feedback butterfly stage: DEPTH-deep feedback line,
// butterfly add/subtract, twiddle multiply from an external ROM, and ROM phase checking.
module sdf_stage_4 #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din_r,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] w_r,
  input  logic [WIDTH-1:0] w_i,
  input  logic [1:0]       rom_state,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout_r,
  output logic [WIDTH-1:0] dout_i,
  output logic             sync_err
);

  localparam int IDXW = $clog2(2 * DEPTH);
  localparam int PW   = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    ROM_FILL = 2'd0,
    ROM_BFLY = 2'd1,
    ROM_MULT = 2'd2
  } rom_state_e;

  logic [IDXW-1:0]  idx_q, idx_d;
  logic             filled_q, filled_d;
  logic [WIDTH-1:0] dl_r_q [DEPTH];
  logic [WIDTH-1:0] dl_i_q [DEPTH];
  logic [WIDTH-1:0] dl_r_d [DEPTH];
  logic [WIDTH-1:0] dl_i_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_r_q, dout_r_d;
  logic [WIDTH-1:0] dout_i_q, dout_i_d;
  logic             sync_err_q, sync_err_d;

  logic             phase_b;
  logic [WIDTH-1:0] head_r, head_i;
  logic [WIDTH-1:0] sum_r, sum_i, diff_r, diff_i;
  logic [WIDTH-1:0] mul_r, mul_i;
  logic signed [PW-1:0] hr_x, hi_x, wr_x, wi_x, pr_full, pi_full;
  rom_state_e       exp_state;

  // DEPTH is a power of two, so the idx MSB alone selects phase B
  assign phase_b = idx_q[IDXW-1];
  assign head_r  = dl_r_q[DEPTH-1];
  assign head_i  = dl_i_q[DEPTH-1];

  always_comb begin
    sum_r  = head_r + din_r;
    sum_i  = head_i + din_i;
    diff_r = head_r - din_r;
    diff_i = head_i - din_i;
  end

  // Full-precision complex multiply; the shift by FRAC floors toward -inf
  always_comb begin
    hr_x    = {{(WIDTH + 1){head_r[WIDTH-1]}}, head_r};
    hi_x    = {{(WIDTH + 1){head_i[WIDTH-1]}}, head_i};
    wr_x    = {{(WIDTH + 1){w_r[WIDTH-1]}}, w_r};
    wi_x    = {{(WIDTH + 1){w_i[WIDTH-1]}}, w_i};
    pr_full = hr_x * wr_x - hi_x * wi_x;
    pi_full = hr_x * wi_x + hi_x * wr_x;
    mul_r   = pr_full[FRAC +: WIDTH];
    mul_i   = pi_full[FRAC +: WIDTH];
  end

  always_comb begin
    idx_d       = idx_q;
    filled_d    = filled_q;
    dl_r_d      = dl_r_q;
    dl_i_d      = dl_i_q;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    sync_err_d  = sync_err_q;
    exp_state   = ROM_FILL;
    if (in_valid) begin
      idx_d = idx_q + 1'b1;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        dl_r_d[k] = dl_r_q[k-1];
        dl_i_d[k] = dl_i_q[k-1];
      end
      if (phase_b) begin
        dl_r_d[0]   = diff_r;
        dl_i_d[0]   = diff_i;
        dout_r_d    = sum_r;
        dout_i_d    = sum_i;
        out_valid_d = 1'b1;
        exp_state   = ROM_BFLY;
      end else begin
        dl_r_d[0] = din_r;
        dl_i_d[0] = din_i;
        if (idx_q == IDXW'(DEPTH - 1)) filled_d = 1'b1;
        if (filled_q) begin
          dout_r_d    = mul_r;
          dout_i_d    = mul_i;
          out_valid_d = 1'b1;
          exp_state   = ROM_MULT;
        end
      end
      if (rom_state != exp_state) sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      filled_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      sync_err_q  <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dl_r_q[k] <= '0;
        dl_i_q[k] <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      filled_q    <= filled_d;
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      sync_err_q  <= sync_err_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dl_r_q[k] <= dl_r_d[k];
        dl_i_q[k] <= dl_i_d[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_sdf_stage_4.sv
// Bench for sdf_stage_4: drives a stage-4 twiddle ROM model and checks against a
// sample-history model of the DIF butterfly plus hand-computed literal sequences.
module tb_sdf_stage_4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [23:0] din_r = '0, din_i = '0;
  logic signed [23:0] w_r, w_i;
  logic [1:0] rom_state;
  logic out_valid, sync_err;
  logic signed [23:0] dout_r, dout_i;

  int vecs = 0;
  int fails = 0;

  sdf_stage_4 #(.WIDTH(24), .FRAC(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .w_r(w_r), .w_i(w_i),
    .rom_state(rom_state), .out_valid(out_valid),
    .dout_r(dout_r), .dout_i(dout_i), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Twiddle ROM: fill steps only on in_valid, later states free-run every cycle
  logic [2:0] rom_cnt;
  logic rom_filled;
  assign rom_state = rom_cnt[2] ? 2'd1 : (rom_filled ? 2'd2 : 2'd0);
  always_comb begin
    case (rom_cnt[1:0])
      2'd0:    begin w_r = 24'sd256;  w_i = 24'sd0;    end
      2'd1:    begin w_r = 24'sd181;  w_i = -24'sd181; end
      2'd2:    begin w_r = 24'sd0;    w_i = -24'sd256; end
      default: begin w_r = -24'sd181; w_i = -24'sd181; end
    endcase
  end

  // Model: history of accepted samples since reset
  logic signed [23:0] xr [0:1023];
  logic signed [23:0] xi [0:1023];
  int n;
  logic exp_v, exp_err;
  logic signed [23:0] exp_r, exp_i;
  int p;
  logic signed [23:0] dr, di;
  longint pr, pim;
  logic [1:0] want;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cnt <= '0; rom_filled <= 1'b0;
      n <= 0; exp_v <= 1'b0; exp_err <= 1'b0; exp_r <= '0; exp_i <= '0;
    end else begin
      if (rom_state == 2'd0) begin
        if (in_valid) begin
          rom_cnt <= rom_cnt + 3'd1;
          if (rom_cnt == 3'd3) rom_filled <= 1'b1;
        end
      end else begin
        rom_cnt <= rom_cnt + 3'd1;
      end
      exp_v <= 1'b0;
      if (in_valid) begin
        p = n % 8;
        xr[n] <= din_r;
        xi[n] <= din_i;
        if (p >= 4) begin
          exp_r <= xr[n-4] + din_r;
          exp_i <= xi[n-4] + din_i;
          exp_v <= 1'b1;
          want = 2'd1;
        end else if (n >= 8) begin
          dr  = xr[n-8] - xr[n-4];
          di  = xi[n-8] - xi[n-4];
          pr  = longint'(dr) * longint'(w_r) - longint'(di) * longint'(w_i);
          pim = longint'(dr) * longint'(w_i) + longint'(di) * longint'(w_r);
          pr  = pr >>> 8;
          pim = pim >>> 8;
          exp_r <= pr[23:0];
          exp_i <= pim[23:0];
          exp_v <= 1'b1;
          want = 2'd2;
        end else begin
          want = 2'd0;
        end
        if (rom_state != want) exp_err <= 1'b1;
        n <= n + 1;
      end
    end
  end

  logic signed [23:0] got_r[$];
  logic signed [23:0] got_i[$];

  always @(negedge clk) begin
    vecs++;
    if (out_valid !== exp_v) begin
      fails++;
      $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, exp_v);
    end
    vecs++;
    if (sync_err !== exp_err) begin
      fails++;
      $display("FAIL sync_err t=%0t got %b want %b", $time, sync_err, exp_err);
    end
    if (exp_v) begin
      vecs++;
      if (dout_r !== exp_r) begin
        fails++;
        $display("FAIL dout_r t=%0t got %0d want %0d", $time, dout_r, exp_r);
      end
      vecs++;
      if (dout_i !== exp_i) begin
        fails++;
        $display("FAIL dout_i t=%0t got %0d want %0d", $time, dout_i, exp_i);
      end
    end
    if (out_valid) begin
      got_r.push_back(dout_r);
      got_i.push_back(dout_i);
    end
  end

  task automatic check(input string name, input longint act, input longint expv);
    vecs++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic drive(input logic v, input logic signed [23:0] r, input logic signed [23:0] i);
    @(negedge clk);
    in_valid = v; din_r = r; din_i = i;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) drive(1'b0, '0, '0);
  endtask

  // Asserted between edges with in_valid left as the stream had it
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_dout_r", longint'(dout_r), 0);
    check("rst_dout_i", longint'(dout_i), 0);
    check("rst_sync_err", longint'(sync_err), 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_r.delete();
    got_i.delete();
  endtask

  task automatic check_seq(input string name, input int cnt, input int er[16], input int ei[16]);
    check({name, "_count"}, got_r.size(), cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k < got_r.size()) begin
        check($sformatf("%s_r%0d", name, k), longint'(got_r[k]), er[k]);
        check($sformatf("%s_i%0d", name, k), longint'(got_i[k]), ei[k]);
      end
    end
  endtask

  function automatic logic signed [23:0] tv_r(input int k);
    return 24'(k * 1237 - 9000);
  endfunction
  function automatic logic signed [23:0] tv_i(input int k);
    return 24'(4000 - k * 611);
  endfunction

  int er[16], ei[16];

  initial begin
    do_reset();

    // Impulse
    for (int k = 0; k < 12; k++) drive(1'b1, (k == 0) ? 24'sd256 : 24'sd0, '0);
    idle(2);
    er = '{256, 0, 0, 0, 256, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ei = '{default: 0};
    check_seq("impulse", 8, er, ei);
    check("impulse_sync_err", longint'(sync_err), 0);

    // Constant input
    do_reset();
    for (int k = 0; k < 12; k++) drive(1'b1, 24'sd256, '0);
    idle(2);
    er = '{512, 512, 512, 512, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("const", 8, er, ei);

    // Mixed complex vectors, then reset mid-stream with in_valid high
    do_reset();
    for (int k = 0; k < 22; k++) drive(1'b1, tv_r(k), tv_i(k));
    do_reset();

    // Twiddle check
    for (int k = 0; k < 12; k++) drive(1'b1, (k >= 4 && k < 8) ? -24'sd256 : 24'sd0, '0);
    idle(2);
    er = '{-256, -256, -256, -256, 256, 181, 0, -181, 0, 0, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, -181, -256, -181, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("twiddle", 8, er, ei);

    // One-cycle gap after idx 5 misaligns the ROM
    do_reset();
    for (int k = 0; k < 6; k++) drive(1'b1, tv_r(k), tv_i(k));
    idle(1);
    for (int k = 6; k < 8; k++) drive(1'b1, tv_r(k), tv_i(k));
    drive(1'b0, '0, '0);
    check("gap1_sync_err", longint'(sync_err), 1);
    for (int k = 8; k < 14; k++) drive(1'b1, tv_r(k), tv_i(k));
    idle(2);
    check("gap1_sticky", longint'(sync_err), 1);

    // Eight-cycle gap keeps the ROM aligned
    do_reset();
    for (int k = 0; k < 6; k++) drive(1'b1, tv_r(k), tv_i(k));
    idle(8);
    for (int k = 6; k < 20; k++) drive(1'b1, tv_r(k), tv_i(k));
    idle(2);
    check("gap8_sync_err", longint'(sync_err), 0);

    // Wrap into a second block
    do_reset();
    for (int k = 0; k < 20; k++)
      drive(1'b1, (k == 0 || (k >= 8 && k < 16)) ? 24'sd256 : 24'sd0, '0);
    idle(2);
    er = '{256, 0, 0, 0, 256, 0, 0, 0, 512, 512, 512, 512, 0, 0, 0, 0};
    ei = '{default: 0};
    check_seq("wrap", 16, er, ei);
    check("wrap_sync_err", longint'(sync_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/sdf_stage_4.md
Name: sdf_stage_4

Overview:
- Radix-2 DIF single-path delay-feedback (SDF) butterfly stage with a 4-deep feedback delay line.
- It is the consumer of the stage-4 twiddle ROM. Each cycle it reads that ROM's w_r/w_i twiddle values and its 2-bit state.
- It performs butterfly add/subtract, then the complex twiddle multiply, and streams results to the next stage.
- It keeps its own phase counter and flags any disagreement with the ROM's state sequence.

Parameters:
- WIDTH, 24: sample and twiddle width, signed two's complement.
- FRAC, 8: twiddle fractional bits (256 = 1.0).
- DEPTH, 4: feedback delay length. Must be a power of 2. The block period is 2*DEPTH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample accepted on a rising edge when high
- din_r  in  WIDTH  input sample, real part
- din_i  in  WIDTH  input sample, imaginary part
- w_r  in  WIDTH  twiddle from ROM, real part, Q(WIDTH-FRAC).FRAC
- w_i  in  WIDTH  twiddle from ROM, imaginary part
- rom_state  in  2  ROM state: 0 = fill, 1 = butterfly, 2 = multiply
- out_valid  out  1  dout is valid this cycle
- dout_r  out  WIDTH  output sample, real part
- dout_i  out  WIDTH  output sample, imaginary part
- sync_err  out  1  sticky: rom_state disagreed with the internal phase

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset rst_n. While rst_n = 0:
  - out_valid, dout_r, dout_i and sync_err are 0.
  - The phase counter idx (log2(2*DEPTH) bits) is 0 and the filled flag is 0.
  - All delay-line entries are 0.
  - Reset mid-stream discards all in-flight data; the next accepted sample is treated as sample 0.
- Acceptance: all state advances only on rising edges with in_valid = 1. With in_valid = 0, everything holds and out_valid is 0 on the next cycle.
- Delay line: a DEPTH-entry shift register of complex values. "head" is the oldest entry. Each accepted sample shifts in exactly one entry.
- Phase A, idx 0..DEPTH-1:
  - Push din.
  - If filled = 0 (fill phase): out_valid = 0 next cycle; expected rom_state = 0.
  - Else: dout = head * W, out_valid = 1; expected rom_state = 2.
- Phase B, idx DEPTH..2*DEPTH-1:
  - dout = head + din, out_valid = 1; expected rom_state = 1.
  - Push head - din.
- Phase counter:
  - idx wraps from 2*DEPTH-1 to 0.
  - filled sets on the first wrap to phase B (idx = DEPTH) and stays set until reset.
- Complex multiply:
  - pr = hr*wr - hi*wi, pi = hr*wi + hi*wr, using full 2*WIDTH+1-bit signed intermediates.
  - Result = arithmetic shift right by FRAC (truncate toward -inf), keep low WIDTH bits.
- Add/subtract: WIDTH-bit two's complement, wraps on overflow, no saturation.
- Latency and timing:
  - Outputs are registered: dout/out_valid appear the cycle after the accepting edge.
  - Sample x[n] contributes to the sum output after x[n+DEPTH] is accepted. Its difference output appears DEPTH accepted samples later.
  - Throughput is 1 sample/cycle; there is no backpressure.
- Twiddle alignment: w_r/w_i are sampled on the same edge as din in phase A. With continuous in_valid, the ROM supplies W8^idx for idx 0..3.
- sync_err:
  - Sets on any accepted edge where rom_state != expected. Stays set until reset.
  - Does not alter the datapath.
  - Note: in states 1/2 the ROM advances even when in_valid = 0. Gaps that are not multiples of 2*DEPTH cycles therefore misalign it, and sync_err flags this.
- Simultaneous events: reset dominates in_valid.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with in_valid = 1 -> out_valid = 0, dout = 0, sync_err = 0 immediately (asynchronous). After release, the first 4 accepted samples produce out_valid = 0.
- Impulse: din_r = 256,0,0,0,0,0,0,0,0,0,0,0 (din_i = 0, continuous, real ROM attached) -> dout_r on the 8 valid outputs = 256,0,0,0,256,0,0,0; dout_i all 0; sync_err = 0.
- Constant input: din_r = 256 for 12 samples -> valid outputs 512,512,512,512,0,0,0,0.
- Twiddle check: x0..x3 = 0, x4..x7 = -256 (0xFFFF00), x8..x11 = 0 -> phase B outputs -256 ×4. Phase A outputs (r,i) = (256,0), (181,-181), (0,-256), (-181,-181).
- Gap tolerance:
  - 1-cycle in_valid gap after idx 5 -> sync_err = 1 by the cycle after idx 7 is accepted.
  - 8-cycle gap at the same point -> sync_err stays 0.
- Wrap: x8..x15 = 256 after an impulse -> second-block sums and products are correct, confirming idx wraps 7 -> 0 without re-entering fill (out_valid stays 1).
